// File: rtl/ps2_key_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_rx
// Purpose  : PS/2 keyboard receiver producing 11-bit {toggle,make,ext,code} key events.
// Option   : PS2_TYPEMATIC_FILTER_EN suppresses repeated makes of the held key.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_rx #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 49152
) (
  input  logic        clk_sys,
  input  logic        I_RESETn,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in,
  output logic [10:0] ps2_key,
  output logic        rx_err
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] c_FILT_LAST = FW'(FILT_LEN - 1);
  localparam logic [TW-1:0] c_TO_MAX    = TW'(TIMEOUT_CYC);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_DATA   = 2'd1;
  localparam logic [1:0] c_PARITY = 2'd2;
  localparam logic [1:0] c_STOP   = 2'd3;

  logic [1:0]    r_rst_pipe;
  logic          w_rst_n;
  logic [1:0]    r_clk_s;
  logic [1:0]    r_dat_s;
  logic          r_clk_f;
  logic          r_clk_f_d;
  logic [FW-1:0] r_filt_cnt;
  logic          w_strobe;
  logic          w_bit;

  logic [1:0]    r_state;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_to_cnt;
  logic          w_timeout;
  logic          w_frame_done;
  logic          w_good;

  logic          r_ext;
  logic          r_brk;
  logic          w_is_e0;
  logic          w_is_f0;
  logic          w_is_ctl;
  logic          w_emit;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk_sys or negedge I_RESETn) begin
    if (!I_RESETn) r_rst_pipe <= 2'b00;
    else           r_rst_pipe <= {r_rst_pipe[0], 1'b1};
  end
  assign w_rst_n = r_rst_pipe[1];

  always_ff @(posedge clk_sys or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_clk_s    <= 2'b11;
      r_dat_s    <= 2'b11;
      r_clk_f    <= 1'b1;
      r_clk_f_d  <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_s   <= {r_clk_s[0], ps2_clk_in};
      r_dat_s   <= {r_dat_s[0], ps2_dat_in};
      r_clk_f_d <= r_clk_f;
      if (r_clk_s[1] != r_clk_f) begin
        if (r_filt_cnt == c_FILT_LAST) begin
          r_clk_f    <= r_clk_s[1];
          r_filt_cnt <= '0;
        end else begin
          r_filt_cnt <= r_filt_cnt + 1'b1;
        end
      end else begin
        r_filt_cnt <= '0;
      end
    end
  end

  assign w_strobe     = r_clk_f_d & ~r_clk_f;
  assign w_bit        = r_dat_s[1];
  assign w_timeout    = (r_state != c_IDLE) && (r_to_cnt == c_TO_MAX);
  assign w_frame_done = w_strobe && (r_state == c_STOP) && !w_timeout;
  // At the stop strobe w_bit is the stop bit; data plus parity must be odd.
  assign w_good       = w_bit && (^{r_shift, r_par});

  always_ff @(posedge clk_sys or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= c_IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      if (w_strobe)
        r_to_cnt <= '0;
      else if ((r_state != c_IDLE) && (r_to_cnt != c_TO_MAX))
        r_to_cnt <= r_to_cnt + 1'b1;

      if (w_timeout) begin
        r_state <= c_IDLE;
      end else if (w_strobe) begin
        case (r_state)
          c_IDLE: begin
            if (!w_bit) begin
              r_state  <= c_DATA;
              r_bitcnt <= '0;
            end
          end
          c_DATA: begin
            r_shift  <= {w_bit, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 3'd7) r_state <= c_PARITY;
          end
          c_PARITY: begin
            r_par   <= w_bit;
            r_state <= c_STOP;
          end
          default: r_state <= c_IDLE;
        endcase
      end
    end
  end

  assign w_is_e0  = (r_shift == 8'hE0);
  assign w_is_f0  = (r_shift == 8'hF0);
  assign w_is_ctl = (r_shift == 8'hFA) || (r_shift == 8'hAA) ||
                    (r_shift == 8'hEE) || (r_shift == 8'hFE);

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0] r_held;
  logic       r_held_v;
  logic       w_match;

  assign w_match = r_held_v && (r_held == {r_ext, r_shift});
  // Breaks always pass; only a repeated make of the held key is swallowed.
  assign w_emit  = r_brk || !w_match;

  always_ff @(posedge clk_sys or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_held   <= '0;
      r_held_v <= 1'b0;
    end else if (w_frame_done && w_good && !w_is_e0 && !w_is_f0 && !w_is_ctl) begin
      if (r_brk) begin
        if (w_match) r_held_v <= 1'b0;
      end else begin
        r_held   <= {r_ext, r_shift};
        r_held_v <= 1'b1;
      end
    end
  end
`else
  assign w_emit = 1'b1;
`endif

  always_ff @(posedge clk_sys or negedge w_rst_n) begin
    if (!w_rst_n) begin
      ps2_key <= '0;
      rx_err  <= 1'b0;
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
    end else begin
      rx_err <= 1'b0;
      if (w_timeout) begin
        rx_err <= 1'b1;
        r_ext  <= 1'b0;
        r_brk  <= 1'b0;
      end else if (w_frame_done) begin
        if (!w_good) begin
          rx_err <= 1'b1;
          r_ext  <= 1'b0;
          r_brk  <= 1'b0;
        end else if (w_is_e0) begin
          r_ext <= 1'b1;
        end else if (w_is_f0) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if (!w_is_ctl && w_emit)
            ps2_key <= {~ps2_key[10], ~r_brk, r_ext, r_shift};
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_rx.sv
`default_nettype none
// Directed bench for ps2_key_rx: frame-level key-event model plus per-cycle hold checks.
module tb_ps2_key_rx;

  localparam int FILT_LEN    = 8;
  localparam int TIMEOUT_CYC = 400;
  localparam int HALF        = 20;
  localparam int GAP         = 40;
`ifdef PS2_TYPEMATIC_FILTER_EN
  localparam bit TF = 1'b1;
`else
  localparam bit TF = 1'b0;
`endif

  logic        clk_sys    = 1'b0;
  logic        I_RESETn   = 1'b0;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_dat_in = 1'b1;
  logic [10:0] ps2_key;
  logic        rx_err;

  ps2_key_rx #(.FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_sys   (clk_sys),
    .I_RESETn  (I_RESETn),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_key   (ps2_key),
    .rx_err    (rx_err)
  );

  always #5 clk_sys = ~clk_sys;

  int          n_vec      = 0;
  int          n_err      = 0;
  int          err_pulses = 0;
  int          toggles    = 0;
  logic        prev_err   = 1'b0;
  logic        prev_t     = 1'b0;
  bit          m_check    = 1'b0;
  logic [10:0] m_key      = '0;
  bit          m_ext      = 1'b0;
  bit          m_brk      = 1'b0;
  bit          m_held_v   = 1'b0;
  logic [8:0]  m_held     = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Key-event rules applied to one good byte; returns 1 when an event is published.
  function automatic bit model_byte(input logic [7:0] b);
    bit ev;
    ev = 1'b0;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE}) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      if (!(TF && !m_brk && m_held_v && m_held == {m_ext, b})) begin
        ev    = 1'b1;
        m_key = {~m_key[10], ~m_brk, m_ext, b};
      end
      if (TF) begin
        if (!m_brk) begin
          m_held   = {m_ext, b};
          m_held_v = 1'b1;
        end else if (m_held_v && m_held == {m_ext, b}) begin
          m_held_v = 1'b0;
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    return ev;
  endfunction

  always @(negedge clk_sys) begin
    if (I_RESETn) begin
      if (rx_err === 1'b1) begin
        err_pulses++;
        chk("rx_err_width", {31'd0, prev_err}, 32'd0);
      end
      if (ps2_key[10] !== prev_t) toggles++;
      if (m_check) begin
        chk("key_hold", {21'd0, ps2_key}, {21'd0, m_key});
        chk("rx_err_quiet", {31'd0, rx_err}, 32'd0);
      end
    end
    prev_err = rx_err;
    prev_t   = ps2_key[10];
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_dat_in = b;
    wait_cyc(HALF);
    ps2_clk_in = 1'b0;
    wait_cyc(HALF);
    ps2_clk_in = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input string tag);
    int e0, t0;
    bit ev, good;
    e0      = err_pulses;
    t0      = toggles;
    good    = !bad_par && !bad_stop;
    m_check = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(!bad_stop);
    ps2_dat_in = 1'b1;
    wait_cyc(GAP);
    if (good) ev = model_byte(b);
    else begin
      ev    = 1'b0;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    chk({tag, "_err"}, err_pulses - e0, good ? 32'd0 : 32'd1);
    chk({tag, "_tog"}, toggles - t0, {31'd0, ev});
    chk({tag, "_key"}, {21'd0, ps2_key}, {21'd0, m_key});
    m_check = 1'b1;
  endtask

  initial begin
    int e0, t0;
    wait_cyc(5);
    chk("reset_key", {21'd0, ps2_key}, 32'd0);
    chk("reset_err", {31'd0, rx_err}, 32'd0);
    I_RESETn = 1'b1;
    wait_cyc(5);
    m_check = 1'b1;

    frame(8'h1C, 0, 0, "make_A");
    chk("lit_make_A", {21'd0, ps2_key}, 32'h61C);

    t0 = toggles;
    frame(8'hE0, 0, 0, "pfx_E0");
    frame(8'hF0, 0, 0, "pfx_F0");
    frame(8'h75, 0, 0, "brk_75");
    chk("lit_brk_75", {22'd0, ps2_key[9:0]}, 32'h175);
    chk("lit_brk_tog", toggles - t0, 32'd1);

    frame(8'h29, 1, 0, "bad_par");
    frame(8'h16, 0, 0, "after_par");
    chk("lit_after_par", {21'd0, ps2_key}, 32'h616);

    // Stall after four data bits.
    e0 = err_pulses;
    m_check = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    wait_cyc(TIMEOUT_CYC + 10);
    chk("timeout_err", err_pulses - e0, 32'd1);
    chk("timeout_key", {21'd0, ps2_key}, {21'd0, m_key});
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_check = 1'b1;
    frame(8'h16, 0, 0, "after_to");
    chk("lit_after_to", {21'd0, ps2_key}, 32'h216);

    // Short low glitch on the clock with data low while idle.
    e0 = err_pulses;
    t0 = toggles;
    ps2_dat_in = 1'b0;
    wait_cyc(5);
    ps2_clk_in = 1'b0;
    wait_cyc(3);
    ps2_clk_in = 1'b1;
    wait_cyc(20);
    ps2_dat_in = 1'b1;
    wait_cyc(10);
    chk("glitch_err", err_pulses - e0, 32'd0);
    chk("glitch_tog", toggles - t0, 32'd0);
    frame(8'h24, 0, 0, "after_glitch");
    chk("lit_after_glitch", {21'd0, ps2_key}, 32'h624);

    t0 = toggles;
    frame(8'h1C, 0, 0, "typ_1");
    frame(8'h1C, 0, 0, "typ_2");
    frame(8'hF0, 0, 0, "typ_F0");
    frame(8'h1C, 0, 0, "typ_brk");
    chk("lit_typ_tog", toggles - t0, TF ? 32'd2 : 32'd3);

    frame(8'hFA, 0, 0, "ack_FA");
    frame(8'hE0, 0, 0, "ext_E0");
    frame(8'h75, 0, 0, "ext_make");
    chk("lit_ext_make", {22'd0, ps2_key[9:0]}, 32'h375);
    frame(8'h33, 0, 1, "bad_stop");

    // Reset in the middle of a frame.
    m_check = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    I_RESETn = 1'b0;
    wait_cyc(3);
    chk("rst_mid_key", {21'd0, ps2_key}, 32'd0);
    chk("rst_mid_err", {31'd0, rx_err}, 32'd0);
    ps2_clk_in = 1'b1;
    ps2_dat_in = 1'b1;
    m_key    = '0;
    m_ext    = 1'b0;
    m_brk    = 1'b0;
    m_held_v = 1'b0;
    e0 = err_pulses;
    I_RESETn = 1'b1;
    wait_cyc(5);
    m_check = 1'b1;
    frame(8'h1C, 0, 0, "post_rst");
    chk("lit_post_rst", {21'd0, ps2_key}, 32'h61C);
    chk("post_rst_err", err_pulses - e0, 32'd0);

    m_check = 1'b0;
    wait_cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
